// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   ALU_OP_W       default opcode width
//   OP_*           opcode encodings
//   state_e        control FSM states (IDLE, MUL, DONE)
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD    = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_SUB    = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_AND    = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_OR     = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_MUL    = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OP_XOR    = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_SLL    = 4'b0111;
    localparam logic [ALU_OP_W-1:0] OP_SRL    = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_PASS_A = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add multiplier, one partial product per cycle.
//   clk, reset_n     clock, asynchronous active-low reset
//   start_i          load operands and begin (ignored while abort_i is high)
//   abort_i          drop any multiplication in progress
//   a_i, b_i         multiplicand / multiplier
//   busy_o           a multiplication is in progress
//   done_o           this cycle is the final step; product_o is the result
//   product_o        accumulator value after the current step (low WIDTH bits)
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    // WIDTH-1 always fits in $clog2(WIDTH) bits.
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // Partial-product add for the current multiplier LSB; bits shifted past
    // WIDTH are dropped, giving the product modulo 2^WIDTH.
    assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Exposing the post-step value lets the caller capture the product on the
    // same edge as the last step, saving a cycle.
    assign product_o = acc_d;
    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (abort_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CW'(WIDTH - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: single-issue ALU with valid/ready handshakes; MUL is iterative.
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid / in_ready  operation handshake (reg_a, reg_b, alu_ctrl)
//   flush                abort any in-flight operation, discard its result
//   out_valid/out_ready  result handshake (result_value, result_zero)
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [OP_W-1:0]  alu_ctrl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_value,
    output logic             result_zero
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             valid_q;
    logic             zero_q;
    logic             accept;
    logic             is_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    // Single-cycle operations. MUL is produced by alu_mul_iter instead.
    function automatic logic [WIDTH-1:0] alu_op(input logic [OP_W-1:0]  op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            OP_W'(OP_ADD):    return a + b;
            OP_W'(OP_SUB):    return a - b;
            OP_W'(OP_AND):    return a & b;
            OP_W'(OP_OR):     return a | b;
            OP_W'(OP_XOR):    return a ^ b;
            OP_W'(OP_SLL):    return a << b[SHW-1:0];
            OP_W'(OP_SRL):    return a >> b[SHW-1:0];
            OP_W'(OP_PASS_A): return a;
            default:          return '0;
        endcase
    endfunction

    // reset_n is included so in_ready stays low throughout reset.
    assign in_ready     = reset_n && (state_q == IDLE) && !flush;
    assign accept       = in_valid && in_ready;
    assign is_mul       = (alu_ctrl == OP_W'(OP_MUL));
    assign result_d     = alu_op(alu_ctrl, reg_a, reg_b);

    assign out_valid    = valid_q;
    assign result_value = result_q;
    assign result_zero  = zero_q;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (accept && is_mul),
        .abort_i   (flush),
        .a_i       (reg_a),
        .b_i       (reg_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else if (flush) begin
            // Flush outranks a same-edge out_ready: nothing is handed over.
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q  <= MUL;
                        end else begin
                            result_q <= result_d;
                            zero_q   <= (result_d == '0);
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result_q <= mul_product;
                        zero_q   <= (mul_product == '0);
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else if (!mul_busy) begin
                        // Multiplier lost its operation; never wait on it.
                        state_q  <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q  <= 1'b0;
                        zero_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    zero_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: self-checking bench for alu_iter (WIDTH=32), scoreboard based.
module tb_alu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;
    logic [3:0]   alu_ctrl;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result_value;
    logic         result_zero;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_iter #(.WIDTH(W), .OP_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .alu_ctrl     (alu_ctrl),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_value (result_value),
        .result_zero  (result_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            4'd1:  model = a + b;
            4'd2:  model = a + ~b + 32'd1;
            4'd3:  model = a & b;
            4'd4:  model = a | b;
            4'd5:  begin p = {32'd0, a} * {32'd0, b}; model = p[W-1:0]; end
            4'd6:  model = a ^ b;
            4'd7:  model = a << b[4:0];
            4'd8:  model = a >> b[4:0];
            4'd15: model = a;
            default: model = '0;
        endcase
    endfunction

    // Present one operation so it is accepted on the next rising edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        exp_t e;
        in_valid = 1'b1;
        alu_ctrl = op;
        reg_a    = a;
        reg_b    = b;
        if (push) begin
            e.res  = model(op, a, b);
            e.zero = (e.res == '0);
            e.lat  = (op == 4'd5) ? W + 1 : 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reg_a    = $urandom;
        reg_b    = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    // Count falling edges until out_valid, bounded.
    task automatic wait_result(output bit got, output int lat, output logic [W-1:0] res,
                               output logic z);
        got = 1'b0; lat = 0; res = '0; z = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) begin
                got = 1'b1;
                res = result_value;
                z   = result_zero;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; reg_a = '0; reg_b = '0; alu_ctrl = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (result_value !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result_value); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (result_zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", result_zero); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        bit got; int lat; logic [W-1:0] r; logic z; exp_t e;
        issue(4'd1, 32'd5, 32'd7, 1'b1);
        wait_result(got, lat, r, z);
        e = sb.pop_front();
        checks++; if (!got || lat != e.lat) begin errors++; $display("FAIL add_latency: got %0d (valid=%0b) want %0d", lat, got, e.lat); end
        checks++; if (r !== e.res) begin errors++; $display("FAIL add_result: got %h want %h", r, e.res); end
        checks++; if (z !== e.zero) begin errors++; $display("FAIL add_zero: got %b want %b", z, e.zero); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_done_ready: got %b want 0", in_ready); end
        consume();
    endtask

    task automatic test_sub_undef();
        bit got; int lat; logic [W-1:0] r; logic z; exp_t e;
        issue(4'd2, 32'd0, 32'd1, 1'b1);
        wait_result(got, lat, r, z);
        e = sb.pop_front();
        checks++; if (!got || lat != e.lat) begin errors++; $display("FAIL sub_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (r !== e.res) begin errors++; $display("FAIL sub_result: got %h want %h", r, e.res); end
        consume();
        issue(4'b1010, 32'h1234_5678, 32'h9abc_def0, 1'b1);
        wait_result(got, lat, r, z);
        e = sb.pop_front();
        checks++; if (!got || r !== e.res) begin errors++; $display("FAIL undef_result: got %h want %h", r, e.res); end
        checks++; if (z !== e.zero) begin errors++; $display("FAIL undef_zero: got %b want %b", z, e.zero); end
        consume();
    endtask

    task automatic test_ops();
        bit got; int lat; logic [W-1:0] r; logic z; exp_t e;
        logic [3:0] ops [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd15, 4'd0, 4'd9, 4'd14, 4'd7};
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], $urandom, (i == 11) ? 32'hFFFF_FFE3 : $urandom, 1'b1);
            wait_result(got, lat, r, z);
            e = sb.pop_front();
            checks++;
            if (!got || lat != e.lat || r !== e.res || z !== e.zero)
                begin errors++; $display("FAIL op_%0d: got %h z=%b lat=%0d want %h z=%b lat=%0d", ops[i], r, z, lat, e.res, e.zero, e.lat); end
            consume();
        end
    endtask

    task automatic test_mul();
        bit got; int lat; logic [W-1:0] r; logic z; exp_t e;
        logic [W-1:0] ma [4] = '{32'h0000_FFFF, 32'h8000_0000, 32'h0001_2345, 32'hFFFF_FFFF};
        logic [W-1:0] mb [4] = '{32'h0001_0001, 32'd2, 32'h0000_6789, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(4'd5, ma[i], mb[i], 1'b1);
            wait_result(got, lat, r, z);
            e = sb.pop_front();
            checks++; if (!got || lat != e.lat) begin errors++; $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, e.lat); end
            checks++; if (r !== e.res || z !== e.zero) begin errors++; $display("FAIL mul%0d_result: got %h z=%b want %h z=%b", i, r, z, e.res, e.zero); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        bit got; int lat; logic [W-1:0] r; logic z; exp_t e;
        issue(4'd1, 32'd100, 32'd23, 1'b1);
        wait_result(got, lat, r, z);
        e = sb.pop_front();
        checks++; if (!got || r !== e.res) begin errors++; $display("FAIL bp_result: got %h want %h", r, e.res); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result_value !== e.res || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold_%0d: valid=%b res=%h ready=%b want 1 %h 0", i, out_valid, result_value, in_ready, e.res); end
        end
        consume();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        bit got; int lat; logic [W-1:0] r; logic z; exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(4'd6, $urandom, $urandom, 1'b1);
            wait_result(got, lat, r, z);
            e = sb.pop_front();
            checks++;
            if (!got || lat != 1 || r !== e.res)
                begin errors++; $display("FAIL b2b_%0d: got %h lat=%0d want %h lat=1", i, r, lat, e.res); end
            consume();
        end
    endtask

    task automatic test_flush();
        bit got; int lat; logic [W-1:0] r; logic z; exp_t e; bit seen;
        issue(4'd5, 32'h1234, 32'h5678, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_mul: valid=%b ready=%b want 0 1", out_valid, in_ready); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL flush_no_output: out_valid seen=%b want 0", seen); end
        issue(4'd1, 32'd1, 32'd1, 1'b1);
        wait_result(got, lat, r, z);
        e = sb.pop_front();
        checks++; if (!got || lat != 1 || r !== e.res) begin errors++; $display("FAIL flush_next_add: got %h lat=%0d want %h", r, lat, e.res); end
        consume();
        // flush together with in_valid: the operation must be refused
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'd1; reg_a = 32'd3; reg_b = 32'd4;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (out_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL flush_refuse: out_valid seen=%b want 0", seen); end
        // flush together with out_ready in DONE
        issue(4'd15, 32'hCAFE_0001, 32'd0, 1'b0);
        wait_result(got, lat, r, z);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (!got || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done: got=%b valid=%b ready=%b want 1 0 1", got, out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_mul();
        bit seen; bit got; int lat; logic [W-1:0] r; logic z; exp_t e;
        issue(4'd5, 32'h0000_0003, 32'h0000_0005, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result_value !== '0 || in_ready !== 1'b0 || result_zero !== 1'b0)
            begin errors++; $display("FAIL reset_mid_mul: valid=%b res=%h ready=%b zero=%b want all 0", out_valid, result_value, in_ready, result_zero); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL reset_no_pulse: out_valid seen=%b want 0", seen); end
        issue(4'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
        wait_result(got, lat, r, z);
        e = sb.pop_front();
        checks++; if (!got || r !== e.res || z !== e.zero) begin errors++; $display("FAIL reset_recover: got %h z=%b want %h z=%b", r, z, e.res, e.zero); end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_undef();
        test_ops();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: %0d entries want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal 8..64).
REQ-002 SHALL have parameter OP_W, default 4, meaning the opcode width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  the reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  marks an operation as presented.
REQ-006 SHALL have port in_ready  output  1  marks that the block can accept an operation.
REQ-007 SHALL have port reg_a  input  WIDTH  operand A.
REQ-008 SHALL have port reg_b  input  WIDTH  operand B.
REQ-009 SHALL have port alu_ctrl  input  OP_W  the opcode.
REQ-010 SHALL have port flush  input  1  aborts any in-flight operation.
REQ-011 SHALL have port out_valid  output  1  marks result_value as valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port result_value  output  WIDTH  the registered result.
REQ-014 SHALL have port result_zero  output  1  high when result_value == 0 while out_valid is high.

Function
REQ-015 Opcodes SHALL be:
  - 0001 ADD
  - 0010 SUB (a-b)
  - 0011 AND
  - 0100 OR
  - 0101 MUL
  - 0110 XOR
  - 0111 SLL (a << b[log2 WIDTH-1:0])
  - 1000 SRL (logical)
  - 1111 PASS_A
  - any other opcode → result 0
REQ-016 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH; MUL returns the low WIDTH bits of the unsigned product.
REQ-017 The FSM SHALL have states IDLE, MUL, DONE.
REQ-018 in_ready SHALL equal (state==IDLE) && !flush.
REQ-019 An operation SHALL be accepted only on a rising edge where in_valid && in_ready; operands and opcode are captured at that edge.
REQ-020 For a non-MUL accept, the block SHALL latch the result and enter DONE, so out_valid is high in the first cycle after the accept edge (latency 1).
REQ-021 For a MUL accept, the block SHALL enter MUL and run a radix-2 shift-add for exactly WIDTH cycles, driven by a down-counter loaded with WIDTH-1, then enter DONE; out_valid first goes high WIDTH+1 cycles after the accept edge.
REQ-022 In DONE, out_valid, result_value and result_zero SHALL hold stable until an edge with out_ready high, after which the state becomes IDLE.
REQ-023 No operation SHALL be accepted while in DONE or MUL (in_ready=0); peak throughput is one op per 2 cycles.
REQ-024 flush high at an edge SHALL force IDLE from any state, deassert out_valid next cycle and discard the result.
REQ-025 When flush and out_ready are both high at the same edge, flush SHALL take priority (the result is discarded, no handshake is counted).
REQ-026 When flush and in_valid are both high, the operation SHALL NOT be accepted.
REQ-027 Input changes while not accepting SHALL have no effect on state.

Reset
REQ-028 Asserting reset_n low SHALL immediately, regardless of clk, force:
  - state IDLE
  - out_valid 0
  - result_value 0
  - counter 0
  - multiplier accumulator 0
REQ-029 While reset_n is low, in_ready SHALL be 0.
REQ-030 The first accept SHALL be possible at the first rising edge after reset_n rises.
REQ-031 Reset during MUL or DONE SHALL abandon the operation with no output pulse.

Structure
REQ-032 Package alu_pkg SHALL hold:
  - opcode localparams (OP_ADD … OP_PASS_A)
  - the FSM state enum
  - the default opcode width
REQ-033 The shift-add datapath SHALL be sub-module alu_mul_iter, with start, busy and done signals, an accumulator and a shifted multiplicand/multiplier, parametrised by WIDTH.

Verification
REQ-034 ADD, WIDTH=32: a=5, b=7, accepted at edge 0 → out_valid in cycle 1, result 12, result_zero 0.
REQ-035 SUB: a=0, b=1 → result 0xFFFFFFFF after 1 cycle; undefined opcode 1010 → result 0, result_zero 1.
REQ-036 MUL: a=0x0000FFFF, b=0x00010001 → out_valid first high 33 cycles after accept, result 0xFFFFFFFF; a=0x80000000, b=2 → result 0, result_zero 1.
REQ-037 Backpressure: out_ready held 0 for 5 cycles after out_valid → result stable, in_ready 0 throughout; out_ready=1 → IDLE next cycle, in_ready 1.
REQ-038 flush asserted in MUL cycle 10 → out_valid never asserted, in_ready 1 next cycle, next ADD 1+1 returns 2; reset_n pulsed low mid-MUL → all outputs 0 immediately.
